feexp_arbiter: RTL and testbench



---
 rtl/fe_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/feexp_arbiter.sv | 118 +++++++++++
 tb/tb_feexp_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared field-arithmetic constants and arbiter state encoding
package fe_pkg;

  localparam int W = 255;

  // 2^255 - 19
  localparam logic [W-1:0] P = {{(W-5){1'b1}}, 5'b01101};

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searches upward from ptr_i with wrap
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            found_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(ptr_i) + i) % NREQ);
      if (valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/feexp_arbiter.sv
// rtl/feexp_arbiter.sv - round-robin sharing of one feexp unit between NREQ requesters
module feexp_arbiter
  import fe_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_out,
  output logic              busy,
  output logic [IDW-1:0]    owner,
  output logic              fx_start,
  output logic [W-1:0]      fx_a,
  output logic [W-1:0]      fx_b,
  input  logic              fx_done,
  input  logic [W-1:0]      fx_out
);

  state_t         state_q, state_d;
  logic           guard_q, guard_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   rsp_q, rsp_d;

  logic           found;
  logic [IDW-1:0] win;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .valid_i(req_valid),
    .ptr_i  (rr_q),
    .found_o(found),
    .idx_o  (win)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      guard_q <= 1'b0;
      rr_q    <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    rsp_d     = rsp_q;
    req_ready = '0;
    rsp_valid = '0;
    fx_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          owner_d        = win;
          a_d            = req_a[int'(win)*W +: W];
          b_d            = req_b[int'(win)*W +: W];
          state_d        = START;
        end
      end
      START: begin
        fx_start = 1'b1;
        guard_d  = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        // fx_done may still be high from the previous operation in the first cycle.
        guard_d = 1'b0;
        if (!guard_q && fx_done) begin
          rsp_d   = fx_out;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
          rr_d    = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;
  assign fx_a    = a_q;
  assign fx_b    = b_q;
  assign rsp_out = rsp_q;

endmodule

// File: tb/tb_feexp_arbiter.sv
// tb/tb_feexp_arbiter.sv - directed self-checking bench for feexp_arbiter with a behavioural feexp
module tb_feexp_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 255;
  localparam int IDW  = 2;
  localparam logic [254:0] P_TB = 255'((256'd1 << 255) - 256'd19);
  localparam logic [255:0] INV7 =
    256'h249249249249249249249249249249249249249249249249249249249249248d;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [W-1:0]      rsp_out;
  logic              busy;
  logic [IDW-1:0]    owner;
  logic              fx_start;
  logic [W-1:0]      fx_a;
  logic [W-1:0]      fx_b;
  logic              fx_done;
  logic [W-1:0]      fx_out;

  always #5 clock = ~clock;

  feexp_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_out  (rsp_out),
    .busy     (busy),
    .owner    (owner),
    .fx_start (fx_start),
    .fx_a     (fx_a),
    .fx_b     (fx_b),
    .fx_done  (fx_done),
    .fx_out   (fx_out)
  );

  function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] t;
    t = {255'd0, x} * {255'd0, y};
    t = t % {255'd0, P_TB};
    return t[254:0];
  endfunction

  function automatic logic [254:0] modexp(input logic [254:0] a, input logic [254:0] b);
    logic [254:0] r;
    logic [254:0] base;
    r    = 255'd1;
    base = mulmod(a, 255'd1);
    for (int i = 254; i >= 0; i--) begin
      r = mulmod(r, r);
      if (b[i]) r = mulmod(r, base);
    end
    return r;
  endfunction

  // feexp model: 4-cycle latency; in sticky mode fx_done and the old result linger one cycle past start
  logic [254:0] m_res = '0;
  logic [254:0] m_out = '0;
  logic         m_done = 1'b0;
  int           m_cnt = 0;
  bit           sticky = 1'b0;

  always @(posedge clock) begin
    if (fx_start) begin
      m_res <= modexp(fx_a, fx_b);
      m_cnt <= 4;
      if (!sticky) m_done <= 1'b0;
    end else if (m_cnt > 1) begin
      m_cnt  <= m_cnt - 1;
      m_done <= 1'b0;
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      m_out  <= m_res;
      m_done <= 1'b1;
    end
  end

  assign fx_done = m_done;
  assign fx_out  = m_out;

  int start_cnt   = 0;
  int multi_ready = 0;
  int grants[$];

  always @(posedge clock) begin
    if (fx_start) begin
      start_cnt <= start_cnt + 1;
      grants.push_back(int'(owner));
    end
  end

  always @(negedge clock) begin
    if ($countones(req_ready) > 1) multi_ready <= multi_ready + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [254:0] a, input logic [254:0] b);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid == '0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_arrived"}, 256'(rsp_valid != '0), 256'(1));
  endtask

  task automatic serve(input string tag, input int k, input logic [255:0] exp,
                       input logic [NREQ-1:0] clr);
    wait_rsp(tag);
    chk({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(4'b0001 << k));
    chk({tag, "_rsp_out"}, 256'(rsp_out), exp);
    chk({tag, "_owner"}, 256'(owner), 256'(k));
    req_valid = req_valid & ~clr;
    rsp_ready = 4'b0001 << k;
    tick();
    rsp_ready = '0;
    #1;
    chk({tag, "_busy_low"}, 256'(busy), 256'(0));
    chk({tag, "_rsp_dropped"}, 256'(rsp_valid), 256'(0));
  endtask

  int s0;

  initial begin
    tick();
    tick();
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_rsp_out", 256'(rsp_out), 256'(0));
    chk("rst_fx_start", 256'(fx_start), 256'(0));
    chk("rst_fx_a", 256'(fx_a), 256'(0));
    chk("rst_fx_b", 256'(fx_b), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_owner", 256'(owner), 256'(0));
    reset = 1'b0;

    // single request 7^2
    s0 = start_cnt;
    set_req(0, 255'd7, 255'd2);
    req_valid = 4'b0001;
    #1;
    chk("single_grant", 256'(req_ready), 256'(4'b0001));
    tick();
    req_valid = '0;
    #1;
    chk("single_start_pulse", 256'(fx_start), 256'(1));
    chk("single_ready_start", 256'(req_ready), 256'(0));
    chk("single_busy", 256'(busy), 256'(1));
    serve("single", 0, 256'd49, 4'b0001);
    chk("single_starts", 256'(start_cnt - s0), 256'(1));

    // three simultaneous requests from a fresh pointer
    do_reset();
    grants.delete();
    set_req(0, 255'((256'd1) << 128), 255'd2);
    set_req(1, 255'd2, 255'd255);
    set_req(2, 255'd2, 255'd254);
    req_valid = 4'b0111;
    serve("three_k0", 0, 256'd38, 4'b0001);
    serve("three_k1", 1, 256'd19, 4'b0010);
    serve("three_k2", 2, 256'd1 << 254, 4'b0100);
    chk("three_ngrants", 256'(grants.size()), 256'(3));
    for (int i = 0; i < 3 && i < grants.size(); i++)
      chk("three_order", 256'(grants[i]), 256'(i));
    chk("three_onehot_ready", 256'(multi_ready), 256'(0));

    // round-robin rotation with all requesters continuously valid
    do_reset();
    grants.delete();
    for (int k = 0; k < NREQ; k++) set_req(k, 255'(k + 2), 255'd3);
    req_valid = 4'b1111;
    serve("rot0", 0, 256'd8, 4'b0000);
    serve("rot1", 1, 256'd27, 4'b0000);
    serve("rot2", 2, 256'd64, 4'b0000);
    serve("rot3", 3, 256'd125, 4'b0000);
    serve("rot4", 0, 256'd8, 4'b0000);
    serve("rot5", 1, 256'd27, 4'b0000);
    serve("rot6", 2, 256'd64, 4'b0000);
    serve("rot7", 3, 256'd125, 4'b1111);
    chk("rot_ngrants", 256'(grants.size()), 256'(8));
    for (int i = 0; i < 8 && i < grants.size(); i++)
      chk("rot_owner_seq", 256'(grants[i]), 256'(i % NREQ));

    // response backpressure, requester 1 waiting
    do_reset();
    set_req(0, 255'd7, 255'd2);
    set_req(1, 255'd3, 255'd3);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    wait_rsp("bp");
    rsp_ready = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("bp_rsp_valid", 256'(rsp_valid), 256'(4'b0001));
      chk("bp_rsp_out", 256'(rsp_out), 256'd49);
      chk("bp_no_grant", 256'(req_ready), 256'(0));
      tick();
    end
    rsp_ready = '0;
    serve("bp_k0", 0, 256'd49, 4'b0000);
    chk("bp_next_grant", 256'(req_ready), 256'(4'b0010));
    serve("bp_k1", 1, 256'd27, 4'b0010);

    // reset during WAIT, stale completion arrives while idle
    set_req(1, 255'd7, 255'd2);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("rw_busy_wait", 256'(busy), 256'(1));
    do_reset();
    #1;
    chk("rw_idle_busy", 256'(busy), 256'(0));
    chk("rw_fx_a_cleared", 256'(fx_a), 256'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rw_no_rsp", 256'(rsp_valid), 256'(0));
    end
    s0 = start_cnt;
    set_req(3, 255'd7, P_TB - 255'd2);
    req_valid = 4'b1000;
    serve("rw_k3", 3, INV7, 4'b1000);
    chk("rw_starts", 256'(start_cnt - s0), 256'(1));

    // stale fx_done/fx_out linger into the first WAIT cycle
    sticky = 1'b1;
    set_req(2, 255'd3, 255'd5);
    req_valid = 4'b0100;
    serve("guard_k2", 2, 256'd243, 4'b0100);
    sticky = 1'b0;

    chk("onehot_ready_all", 256'(multi_ready), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
